// File: rtl/decode_stage_riscv.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_riscv
//  Purpose  : Buffered RV32I(+M) instruction decode stage. Fetched
//             {pc, instr} pairs enter a circular queue. The queue head is
//             decoded combinationally and loaded into a valid/ready output
//             register. After an illegal word is issued, the stage stops
//             popping until flush_i is asserted.
//  Ports    : clk_i, rst_i (async, active-high)
//             instr_i/pc_i/instr_valid_i/instr_ready_o   - fetch side
//             flush_i                                    - trap-unit flush
//             dec_valid_o/dec_ready_i                    - execute side
//             dec_pc_o, dec_instr_o, *_sel_o, *_op_o,
//             control strobes, mdu_o/mdu_op_o            - decoded word
//             count_o                                    - queue occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage_riscv #(
  parameter int          DEPTH    = 4,
  parameter int unsigned ENABLE_M = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [31:0]                instr_i,
  input  logic [31:0]                pc_i,
  input  logic                       instr_valid_i,
  output logic                       instr_ready_o,
  input  logic                       flush_i,
  output logic                       dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [31:0]                dec_pc_o,
  output logic [31:0]                dec_instr_o,
  output logic [1:0]                 a_sel_o,
  output logic [2:0]                 b_sel_o,
  output logic [4:0]                 alu_op_o,
  output logic [2:0]                 csr_op_o,
  output logic [2:0]                 mem_size_o,
  output logic [1:0]                 wb_sel_o,
  output logic                       csr_we_o,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic                       gpr_we_o,
  output logic                       branch_o,
  output logic                       jal_o,
  output logic                       jalr_o,
  output logic                       mret_o,
  output logic                       illegal_instr_o,
  output logic                       mdu_o,
  output logic [2:0]                 mdu_op_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  // --------------------------------------------------------------------------
  // Control-field encodings (riscv_pkg values)
  // --------------------------------------------------------------------------
  localparam logic [1:0] OP_A_RS1     = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;

  localparam logic [2:0] OP_B_RS2     = 3'd0;
  localparam logic [2:0] OP_B_IMM_I   = 3'd1;
  localparam logic [2:0] OP_B_IMM_S   = 3'd2;
  localparam logic [2:0] OP_B_IMM_U   = 3'd4;
  localparam logic [2:0] OP_B_INCR    = 3'd6;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_EQ   = 5'd10;
  localparam logic [4:0] ALU_NE   = 5'd11;
  localparam logic [4:0] ALU_LTS  = 5'd12;
  localparam logic [4:0] ALU_GES  = 5'd13;
  localparam logic [4:0] ALU_LTU  = 5'd14;
  localparam logic [4:0] ALU_GEU  = 5'd15;

  localparam logic [1:0] WB_EX_RESULT = 2'd0;
  localparam logic [1:0] WB_LSU_DATA  = 2'd1;
  localparam logic [1:0] WB_CSR_DATA  = 2'd2;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] MRET_WORD   = 32'h3020_0073;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Queue storage and pointers
  // --------------------------------------------------------------------------
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  state_t        r_state;
  state_t        w_state_next;

  // Full is derived from the registered count only, so a pop in the same
  // cycle never opens the door for a push into a full queue.
  assign w_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign instr_ready_o = !w_full && !flush_i;
  assign w_push        = instr_valid_i && instr_ready_o;
  assign count_o       = r_count;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wptr]    <= pc_i;
      r_instr_mem[r_wptr] <= instr_i;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Combinational decode of the queue head
  // --------------------------------------------------------------------------
  logic [31:0] w_head_instr;
  logic [31:0] w_head_pc;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;

  assign w_head_instr = r_instr_mem[r_rptr];
  assign w_head_pc    = r_pc_mem[r_rptr];
  assign w_opcode     = w_head_instr[6:0];
  assign w_funct3     = w_head_instr[14:12];
  assign w_funct7     = w_head_instr[31:25];

  logic [1:0] w_a_sel;
  logic [2:0] w_b_sel;
  logic [4:0] w_alu_op;
  logic [2:0] w_csr_op;
  logic [2:0] w_mem_size;
  logic [1:0] w_wb_sel;
  logic       w_csr_we;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_gpr_we;
  logic       w_branch;
  logic       w_jal;
  logic       w_jalr;
  logic       w_mret;
  logic       w_mdu;
  logic [2:0] w_mdu_op;
  logic       w_illegal;

  always_comb begin
    w_a_sel    = OP_A_RS1;
    w_b_sel    = OP_B_RS2;
    w_alu_op   = ALU_ADD;
    w_csr_op   = 3'd0;
    w_mem_size = 3'd0;
    w_wb_sel   = WB_EX_RESULT;
    w_csr_we   = 1'b0;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_gpr_we   = 1'b0;
    w_branch   = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_mret     = 1'b0;
    w_mdu      = 1'b0;
    w_mdu_op   = 3'd0;
    w_illegal  = 1'b0;

    if (w_opcode[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opcode)
        OPC_OP: begin
          w_gpr_we = 1'b1;
          if (w_funct7 == 7'b0000000) begin
            case (w_funct3)
              3'd0:    w_alu_op = ALU_ADD;
              3'd1:    w_alu_op = ALU_SLL;
              3'd2:    w_alu_op = ALU_SLT;
              3'd3:    w_alu_op = ALU_SLTU;
              3'd4:    w_alu_op = ALU_XOR;
              3'd5:    w_alu_op = ALU_SRL;
              3'd6:    w_alu_op = ALU_OR;
              default: w_alu_op = ALU_AND;
            endcase
          end else if (w_funct7 == 7'b0100000) begin
            if (w_funct3 == 3'd0)      w_alu_op  = ALU_SUB;
            else if (w_funct3 == 3'd5) w_alu_op  = ALU_SRA;
            else                       w_illegal = 1'b1;
          end else if ((w_funct7 == 7'b0000001) && (ENABLE_M != 0)) begin
            w_mdu    = 1'b1;
            w_mdu_op = w_funct3;
          end else begin
            w_illegal = 1'b1;
          end
        end

        OPC_OP_IMM: begin
          w_gpr_we = 1'b1;
          w_b_sel  = OP_B_IMM_I;
          case (w_funct3)
            3'd0: w_alu_op = ALU_ADD;
            3'd1: begin
              if (w_funct7 == 7'b0000000) w_alu_op  = ALU_SLL;
              else                        w_illegal = 1'b1;
            end
            3'd2: w_alu_op = ALU_SLT;
            3'd3: w_alu_op = ALU_SLTU;
            3'd4: w_alu_op = ALU_XOR;
            3'd5: begin
              if (w_funct7 == 7'b0000000)      w_alu_op  = ALU_SRL;
              else if (w_funct7 == 7'b0100000) w_alu_op  = ALU_SRA;
              else                             w_illegal = 1'b1;
            end
            3'd6:    w_alu_op = ALU_OR;
            default: w_alu_op = ALU_AND;
          endcase
        end

        OPC_LOAD: begin
          w_mem_req  = 1'b1;
          w_mem_size = w_funct3;
          w_gpr_we   = 1'b1;
          w_wb_sel   = WB_LSU_DATA;
          w_b_sel    = OP_B_IMM_I;
          if ((w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7))
            w_illegal = 1'b1;
        end

        OPC_STORE: begin
          w_mem_req  = 1'b1;
          w_mem_we   = 1'b1;
          w_mem_size = w_funct3;
          w_b_sel    = OP_B_IMM_S;
          if (w_funct3 > 3'd2) w_illegal = 1'b1;
        end

        OPC_LUI: begin
          w_gpr_we = 1'b1;
          w_a_sel  = OP_A_ZERO;
          w_b_sel  = OP_B_IMM_U;
        end

        OPC_AUIPC: begin
          w_gpr_we = 1'b1;
          w_a_sel  = OP_A_CURR_PC;
          w_b_sel  = OP_B_IMM_U;
        end

        OPC_BRANCH: begin
          w_branch = 1'b1;
          case (w_funct3)
            3'd0:    w_alu_op = ALU_EQ;
            3'd1:    w_alu_op = ALU_NE;
            3'd4:    w_alu_op = ALU_LTS;
            3'd5:    w_alu_op = ALU_GES;
            3'd6:    w_alu_op = ALU_LTU;
            3'd7:    w_alu_op = ALU_GEU;
            default: w_illegal = 1'b1;
          endcase
        end

        OPC_JAL: begin
          w_jal    = 1'b1;
          w_gpr_we = 1'b1;
          w_a_sel  = OP_A_CURR_PC;
          w_b_sel  = OP_B_INCR;
        end

        OPC_JALR: begin
          w_jalr   = 1'b1;
          w_gpr_we = 1'b1;
          w_a_sel  = OP_A_CURR_PC;
          w_b_sel  = OP_B_INCR;
          if (w_funct3 != 3'd0) w_illegal = 1'b1;
        end

        OPC_MISC_MEM: begin
          if (w_funct3 != 3'd0) w_illegal = 1'b1;
        end

        OPC_SYSTEM: begin
          if ((w_funct3 != 3'd0) && (w_funct3 != 3'd4)) begin
            w_csr_op = w_funct3;
            w_csr_we = 1'b1;
            w_gpr_we = 1'b1;
            w_wb_sel = WB_CSR_DATA;
          end else if (w_head_instr == MRET_WORD) begin
            w_mret = 1'b1;
          end else begin
            // ecall, ebreak, wfi and any other privileged encoding trap here
            w_illegal = 1'b1;
          end
        end

        default: w_illegal = 1'b1;
      endcase
    end

    // An illegal word carries no side effects downstream.
    if (w_illegal) begin
      w_a_sel    = OP_A_RS1;
      w_b_sel    = OP_B_RS2;
      w_alu_op   = ALU_ADD;
      w_csr_op   = 3'd0;
      w_mem_size = 3'd0;
      w_wb_sel   = WB_EX_RESULT;
      w_csr_we   = 1'b0;
      w_mem_req  = 1'b0;
      w_mem_we   = 1'b0;
      w_gpr_we   = 1'b0;
      w_branch   = 1'b0;
      w_jal      = 1'b0;
      w_jalr     = 1'b0;
      w_mret     = 1'b0;
      w_mdu      = 1'b0;
      w_mdu_op   = 3'd0;
    end
  end

  // --------------------------------------------------------------------------
  // RUN/LOCK state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_pop = !flush_i && !w_empty && (!dec_valid_o || dec_ready_i);
        if (w_pop && w_illegal) w_state_next = ST_LOCK;
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
    if (flush_i) w_state_next = ST_RUN;
  end

  // --------------------------------------------------------------------------
  // Output register: loads only on a pop, so every field holds while stalled
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_valid_o     <= 1'b0;
      dec_pc_o        <= '0;
      dec_instr_o     <= '0;
      a_sel_o         <= '0;
      b_sel_o         <= '0;
      alu_op_o        <= ALU_ADD;
      csr_op_o        <= '0;
      mem_size_o      <= '0;
      wb_sel_o        <= '0;
      csr_we_o        <= 1'b0;
      mem_req_o       <= 1'b0;
      mem_we_o        <= 1'b0;
      gpr_we_o        <= 1'b0;
      branch_o        <= 1'b0;
      jal_o           <= 1'b0;
      jalr_o          <= 1'b0;
      mret_o          <= 1'b0;
      illegal_instr_o <= 1'b0;
      mdu_o           <= 1'b0;
      mdu_op_o        <= '0;
    end else if (flush_i) begin
      dec_valid_o <= 1'b0;
    end else if (w_pop) begin
      dec_valid_o     <= 1'b1;
      dec_pc_o        <= w_head_pc;
      dec_instr_o     <= w_head_instr;
      a_sel_o         <= w_a_sel;
      b_sel_o         <= w_b_sel;
      alu_op_o        <= w_alu_op;
      csr_op_o        <= w_csr_op;
      mem_size_o      <= w_mem_size;
      wb_sel_o        <= w_wb_sel;
      csr_we_o        <= w_csr_we;
      mem_req_o       <= w_mem_req;
      mem_we_o        <= w_mem_we;
      gpr_we_o        <= w_gpr_we;
      branch_o        <= w_branch;
      jal_o           <= w_jal;
      jalr_o          <= w_jalr;
      mret_o          <= w_mret;
      illegal_instr_o <= w_illegal;
      mdu_o           <= w_mdu;
      mdu_op_o        <= w_mdu_op;
    end else if (dec_valid_o && dec_ready_i) begin
      dec_valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire
